// File: rtl/riscv_icache_pkg.sv
// -----------------------------------------------------------------------------
// riscv_icache_pkg
//   Shared definitions for the N-way set-associative instruction cache:
//   the controller state enum, the address-field width derivations and the
//   fetch width (one 64-bit beat = two 32-bit instructions).
//   Optional feature macro used by the cache top: RISCV_ICACHE_PERF_EN.
// -----------------------------------------------------------------------------
package riscv_icache_pkg;

  localparam int FETCH_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_REPLAY = 2'd2,
    ST_INVAL  = 2'd3
  } state_e;

  // Byte-offset width within a line (LINE_WORDS 32-bit words).
  function automatic int calc_off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  // Set-index width.
  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Tag width for a 32-bit address.
  function automatic int calc_tag_w(input int sets, input int line_words);
    return 32 - calc_idx_w(sets) - calc_off_w(line_words);
  endfunction

endpackage

// File: rtl/riscv_icache_tag_array.sv
// -----------------------------------------------------------------------------
// riscv_icache_tag_array
//   Tag, valid and round-robin replacement state for the instruction cache.
//   Ports:
//     clk, i_srst            clock, synchronous active-high reset
//     i_lk_index, i_lk_tag   lookup set and tag (combinational result)
//     o_lk_hit, o_lk_way     hit flag and hitting way
//     o_vic_way              victim for i_lk_index: lowest invalid way,
//                            otherwise the set's round-robin pointer
//     i_fill_start           write tag and clear valid of (index, way)
//     i_fill_done            set valid of (index, way), advance set pointer
//     i_fill_index/way/tag   target of the fill
//     i_clr_en, i_clr_index  clear all valid bits and the pointer of one set
// -----------------------------------------------------------------------------
module riscv_icache_tag_array #(
  parameter int WAYS  = 2,
  parameter int SETS  = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 21,
  parameter int WAY_W = 1
) (
  input  logic             clk,
  input  logic             i_srst,
  input  logic [IDX_W-1:0] i_lk_index,
  input  logic [TAG_W-1:0] i_lk_tag,
  output logic             o_lk_hit,
  output logic [WAY_W-1:0] o_lk_way,
  output logic [WAY_W-1:0] o_vic_way,
  input  logic             i_fill_start,
  input  logic             i_fill_done,
  input  logic [IDX_W-1:0] i_fill_index,
  input  logic [WAY_W-1:0] i_fill_way,
  input  logic [TAG_W-1:0] i_fill_tag,
  input  logic             i_clr_en,
  input  logic [IDX_W-1:0] i_clr_index
);

  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAY_W-1:0] r_rr    [SETS];

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    o_lk_hit  = 1'b0;
    o_lk_way  = '0;
    o_vic_way = r_rr[i_lk_index];
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[i_lk_index][w] && (r_tag[i_lk_index][w] == i_lk_tag)) begin
        o_lk_hit = 1'b1;
        o_lk_way = WAY_W'(w);
      end
    end
    // Scan downwards so the lowest-numbered invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[i_lk_index][w]) o_vic_way = WAY_W'(w);
    end
  end

  // NOTE: the tag store is plain memory and is not reset; the valid bits
  // alone decide whether a tag means anything.
  always_ff @(posedge clk) begin
    if (i_fill_start) r_tag[i_fill_index][i_fill_way] <= i_fill_tag;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (i_srst) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      if (i_clr_en) begin
        r_valid[i_clr_index] <= '0;
        r_rr[i_clr_index]    <= '0;
      end
      if (i_fill_start) r_valid[i_fill_index][i_fill_way] <= 1'b0;
      // Later assignment wins: a single-beat line starts and completes at once.
      if (i_fill_done) begin
        r_valid[i_fill_index][i_fill_way] <= 1'b1;
        r_rr[i_fill_index] <= (r_rr[i_fill_index] == WAY_W'(WAYS - 1)) ?
                              '0 : r_rr[i_fill_index] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscv_icache_nway.sv
// -----------------------------------------------------------------------------
// riscv_icache_nway
//   N-way set-associative instruction cache serving 64-bit fetches. Tags and
//   valid bits are internal; line data sits in external per-way SRAMs with
//   asynchronous read. Misses refill one 64-bit beat per reload_ack, then the
//   latched pc is replayed. fence.i invalidate clears one set per cycle.
//   Ports:
//     clk, srst                          clock, synchronous active-high reset
//     read_req, pc, read_ack             fetch request / accept (comb)
//     kill, invalidate                   redirect, fence.i pulse
//     data_val, data                     one-cycle delivery pulse, held data
//     way_rdata/ren/wen/index/beat/wdata per-way SRAM interface
//     reload_req/addr/ack/data           refill beat interface
//     hit_cnt, miss_cnt                  only with RISCV_ICACHE_PERF_EN
// -----------------------------------------------------------------------------
module riscv_icache_nway
  import riscv_icache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 8,
  localparam int OFF_W  = calc_off_w(LINE_WORDS),
  localparam int IDX_W  = calc_idx_w(SETS),
  localparam int TAG_W  = calc_tag_w(SETS, LINE_WORDS),
  localparam int BEATS  = LINE_WORDS / 2,
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    read_req,
  input  logic [31:0]             pc,
  input  logic                    kill,
  input  logic                    invalidate,
  output logic                    read_ack,
  output logic                    data_val,
  output logic [FETCH_W-1:0]      data,
  input  logic [WAYS*FETCH_W-1:0] way_rdata,
  output logic [WAYS-1:0]         way_ren,
  output logic [WAYS-1:0]         way_wen,
  output logic [IDX_W-1:0]        way_index,
  output logic [BEAT_W-1:0]       way_beat,
  output logic [FETCH_W-1:0]      way_wdata,
  output logic                    reload_req,
  output logic [31:0]             reload_addr,
  input  logic                    reload_ack,
  input  logic [FETCH_W-1:0]      reload_data
`ifdef RISCV_ICACHE_PERF_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
`endif
);

  state_e             r_state;
  logic [31:0]        r_pc;
  logic [BEAT_W-1:0]  r_beat;
  logic [WAY_W-1:0]   r_vway;
  logic               r_killed;
  logic               r_inval_pending;
  logic [IDX_W-1:0]   r_inval_idx;
  logic               r_data_val;
  logic [FETCH_W-1:0] r_data;

  logic [31:0]        w_lk_pc;
  logic [IDX_W-1:0]   w_lk_index;
  logic [TAG_W-1:0]   w_lk_tag;
  logic [BEAT_W-1:0]  w_lk_beat;
  logic               w_lk_hit;
  logic [WAY_W-1:0]   w_lk_way;
  logic [WAY_W-1:0]   w_vic_way;
  logic [FETCH_W-1:0] w_sel_data;
  logic               w_refill_ack;
  logic               w_last_beat;
  logic               w_ren_en;

  // IDLE looks up the incoming pc; REFILL and REPLAY work on the latched one.
  assign w_lk_pc    = (r_state == ST_IDLE) ? pc : r_pc;
  assign w_lk_index = w_lk_pc[OFF_W +: IDX_W];
  assign w_lk_tag   = w_lk_pc[31 -: TAG_W];
  assign w_lk_beat  = BEAT_W'(w_lk_pc >> 3);

  assign read_ack = (r_state == ST_IDLE) & read_req & ~kill & ~invalidate &
                    ~r_inval_pending;

  assign w_refill_ack = (r_state == ST_REFILL) & reload_ack;
  assign w_last_beat  = (r_beat == BEAT_W'(BEATS - 1));
  assign w_ren_en     = w_lk_hit & (read_ack | (r_state == ST_REPLAY));
  assign w_sel_data   = way_rdata[int'(w_lk_way) * FETCH_W +: FETCH_W];

  assign way_index   = w_lk_index;
  assign way_beat    = (r_state == ST_REFILL) ? r_beat : w_lk_beat;
  assign way_ren     = w_ren_en ? (WAYS'(1) << w_lk_way) : '0;
  assign way_wen     = w_refill_ack ? (WAYS'(1) << r_vway) : '0;
  assign way_wdata   = reload_data;
  assign reload_req  = (r_state == ST_REFILL);
  assign reload_addr = {r_pc[31:OFF_W], {OFF_W{1'b0}}} | (32'(r_beat) << 3);
  assign data_val    = r_data_val;
  assign data        = r_data;

  riscv_icache_tag_array #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .WAY_W (WAY_W)
  ) u_tags (
    .clk          (clk),
    .i_srst       (srst),
    .i_lk_index   (w_lk_index),
    .i_lk_tag     (w_lk_tag),
    .o_lk_hit     (w_lk_hit),
    .o_lk_way     (w_lk_way),
    .o_vic_way    (w_vic_way),
    .i_fill_start (w_refill_ack & (r_beat == '0)),
    .i_fill_done  (w_refill_ack & w_last_beat),
    .i_fill_index (w_lk_index),
    .i_fill_way   (r_vway),
    .i_fill_tag   (w_lk_tag),
    .i_clr_en     (r_state == ST_INVAL),
    .i_clr_index  (r_inval_idx)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state         <= ST_IDLE;
      r_pc            <= '0;
      r_beat          <= '0;
      r_vway          <= '0;
      r_killed        <= 1'b0;
      r_inval_pending <= 1'b0;
      r_inval_idx     <= '0;
      r_data_val      <= 1'b0;
      r_data          <= '0;
    end else begin
      r_data_val <= 1'b0;
      // An invalidate outside IDLE waits until the controller is back there.
      if (invalidate && (r_state != ST_IDLE)) r_inval_pending <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (r_inval_pending || invalidate) begin
            r_state         <= ST_INVAL;
            r_inval_idx     <= '0;
            r_inval_pending <= 1'b0;
          end else if (read_ack) begin
            r_pc <= pc;
            if (w_lk_hit) begin
              r_data     <= w_sel_data;
              r_data_val <= 1'b1;
            end else begin
              r_state  <= ST_REFILL;
              r_beat   <= '0;
              r_vway   <= w_vic_way;
              r_killed <= 1'b0;
            end
          end
        end
        ST_REFILL: begin
          // A kill only drops the delivery; the line is still installed.
          if (kill) r_killed <= 1'b1;
          if (reload_ack) begin
            r_beat <= r_beat + 1'b1;
            if (w_last_beat) r_state <= ST_REPLAY;
          end
        end
        ST_REPLAY: begin
          if (!r_killed && !kill) begin
            r_data     <= w_sel_data;
            r_data_val <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        ST_INVAL: begin
          r_inval_idx <= r_inval_idx + 1'b1;
          if (r_inval_idx == IDX_W'(SETS - 1)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef RISCV_ICACHE_PERF_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Counted at acceptance, so fetches killed later are still included.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (read_ack) begin
      if (w_lk_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else          r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_riscv_icache_nway.sv
// -----------------------------------------------------------------------------
// tb_riscv_icache_nway
//   Self-checking bench for riscv_icache_nway (WAYS=2, SETS=64, LINE_WORDS=8).
//   Models the per-way SRAMs and a backing memory whose beat data is a fixed
//   function of the beat address. A vector table drives fetch sequences with
//   hand-derived hit/miss, way and latency expectations; hand-written sequences
//   cover kill, invalidate and reset in the middle of a refill.
//   Set RISCV_ICACHE_PERF_EN to also check the hit/miss counters.
// -----------------------------------------------------------------------------
module tb_riscv_icache_nway;

  localparam int WAYS       = 2;
  localparam int SETS       = 64;
  localparam int LINE_WORDS = 8;
  localparam int BEATS      = LINE_WORDS / 2;
  localparam int MISS_LAT   = BEATS + 2;

  logic                 clk = 1'b0;
  logic                 srst;
  logic                 read_req;
  logic [31:0]          pc;
  logic                 kill;
  logic                 invalidate;
  logic                 read_ack;
  logic                 data_val;
  logic [63:0]          data;
  logic [WAYS*64-1:0]   way_rdata;
  logic [WAYS-1:0]      way_ren;
  logic [WAYS-1:0]      way_wen;
  logic [5:0]           way_index;
  logic [1:0]           way_beat;
  logic [63:0]          way_wdata;
  logic                 reload_req;
  logic [31:0]          reload_addr;
  logic                 reload_ack;
  logic [63:0]          reload_data;
`ifdef RISCV_ICACHE_PERF_EN
  logic [31:0]          hit_cnt;
  logic [31:0]          miss_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] addr_q[$];

  always #5 clk = ~clk;

  riscv_icache_nway #(
    .WAYS       (WAYS),
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS)
  ) dut (
    .clk         (clk),
    .srst        (srst),
    .read_req    (read_req),
    .pc          (pc),
    .kill        (kill),
    .invalidate  (invalidate),
    .read_ack    (read_ack),
    .data_val    (data_val),
    .data        (data),
    .way_rdata   (way_rdata),
    .way_ren     (way_ren),
    .way_wen     (way_wen),
    .way_index   (way_index),
    .way_beat    (way_beat),
    .way_wdata   (way_wdata),
    .reload_req  (reload_req),
    .reload_addr (reload_addr),
    .reload_ack  (reload_ack),
    .reload_data (reload_data)
`ifdef RISCV_ICACHE_PERF_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  // Per-way line SRAMs: synchronous write, asynchronous read.
  logic [63:0] sram [WAYS][SETS][BEATS];

  always @(posedge clk) begin
    for (int w = 0; w < WAYS; w++)
      if (way_wen[w]) sram[w][way_index][way_beat] <= way_wdata;
  end

  always_comb begin
    way_rdata = '0;
    for (int w = 0; w < WAYS; w++)
      way_rdata[w*64 +: 64] = sram[w][way_index][way_beat];
  end

  // Backing-memory content of the 8-byte beat holding addr.
  function automatic logic [63:0] beat_data(input logic [31:0] addr);
    logic [31:0] b;
    b = {addr[31:3], 3'b000};
    return {b ^ 32'hCAFE_0000, ~b};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request at a negedge; return the combinational accept/ren.
  task automatic issue(input logic [31:0] a, output logic ack,
                       output logic [WAYS-1:0] ren);
    @(negedge clk);
    read_req = 1'b1;
    pc       = a;
    #1;
    ack = read_ack;
    ren = way_ren;
  endtask

  // After an accept: serve refill beats until data_val or the cycle budget
  // runs out. kill/invalidate are pulsed on the given ack number (-1: never).
  task automatic serve(input int kill_at, input int inval_at, output int lat,
                       output logic got_val, output logic [63:0] got_data,
                       output int wr_way);
    int acks;
    acks = 0; lat = 0; got_val = 1'b0; got_data = '0; wr_way = -1;
    addr_q.delete();
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      read_req = 1'b0; kill = 1'b0; invalidate = 1'b0; reload_ack = 1'b0;
      if (data_val) begin
        lat = c; got_val = 1'b1; got_data = data;
        break;
      end
      if (reload_req) begin
        reload_ack  = 1'b1;
        reload_data = beat_data(reload_addr);
        addr_q.push_back(reload_addr);
        if (acks == kill_at)  kill = 1'b1;
        if (acks == inval_at) invalidate = 1'b1;
        acks++;
        #1;
        for (int w = 0; w < WAYS; w++) if (way_wen[w]) wr_way = w;
      end
      @(posedge clk);
    end
    reload_ack = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input int kill_at, input int inval_at,
                       output logic ack, output logic [WAYS-1:0] ren,
                       output int lat, output logic val,
                       output logic [63:0] d, output int wr_way);
    issue(a, ack, ren);
    if (ack) serve(kill_at, inval_at, lat, val, d, wr_way);
    else begin
      read_req = 1'b0; lat = 0; val = 1'b0; d = '0; wr_way = -1;
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        miss;
    int          way;   // way holding (hit) or receiving (miss) the line
  } vec_t;

  task automatic apply(input vec_t v, input string tag);
    logic ack, val;
    logic [WAYS-1:0] ren;
    logic [63:0] d;
    int lat, wr;
    fetch(v.pc, -1, -1, ack, ren, lat, val, d, wr);
    check({tag, " read_ack"}, 64'(ack), 64'd1);
    check({tag, " way_ren"}, 64'(ren), v.miss ? 64'd0 : 64'(1 << v.way));
    check({tag, " data_val"}, 64'(val), 64'd1);
    check({tag, " data"}, d, beat_data(v.pc));
    check({tag, " latency"}, 64'(lat), v.miss ? 64'(MISS_LAT) : 64'd1);
    if (v.miss) check({tag, " victim"}, 64'(wr), 64'(v.way));
    @(negedge clk);
    check({tag, " pulse"}, 64'(data_val), 64'd0);
  endtask

  vec_t vecs[10];
  vec_t perf_vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ack, val;
    logic [WAYS-1:0] ren;
    logic [63:0] d;
    int lat, wr, zeros;

    // Set 8 holds 0x100, 0x900, 0x1100, 0x1900 (index = pc[10:5]).
    vecs[0] = '{32'h0000_0100, 1'b1, 0};  // cold: first invalid way
    vecs[1] = '{32'h0000_0104, 1'b0, 0};
    vecs[2] = '{32'h0000_011C, 1'b0, 0};  // last beat, pc[2:0] ignored
    vecs[3] = '{32'h0000_0900, 1'b1, 1};  // way 1 still invalid
    vecs[4] = '{32'h0000_0100, 1'b0, 0};
    vecs[5] = '{32'h0000_1100, 1'b1, 0};  // set full, pointer 0
    vecs[6] = '{32'h0000_0908, 1'b0, 1};
    vecs[7] = '{32'h0000_1900, 1'b1, 1};  // pointer 1
    vecs[8] = '{32'h0000_1110, 1'b0, 0};
    vecs[9] = '{32'h0000_0100, 1'b1, 0};  // evicted, refill via pointer 0

    perf_vecs[0] = '{32'h0000_0100, 1'b1, 0};
    perf_vecs[1] = '{32'h0000_0104, 1'b0, 0};
    perf_vecs[2] = '{32'h0000_0108, 1'b0, 0};
    perf_vecs[3] = '{32'h0000_0900, 1'b1, 1};
    perf_vecs[4] = '{32'h0000_0904, 1'b0, 1};

    srst = 1'b1; read_req = 1'b0; pc = '0; kill = 1'b0; invalidate = 1'b0;
    reload_ack = 1'b0; reload_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    check("reset data_val", 64'(data_val), 64'd0);
    check("reset data", data, 64'd0);
    check("reset reload_req", 64'(reload_req), 64'd0);

    // Table-driven fill / hit / eviction sequence.
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        check("refill beats", 64'(addr_q.size()), 64'(BEATS));
        for (int b = 0; b < BEATS && b < addr_q.size(); b++)
          check($sformatf("reload_addr%0d", b), 64'(addr_q[b]),
                64'(32'h100 + 8 * b));
      end
    end

    // Kill on the second refill ack: no delivery, but the line is installed.
    fetch(32'h2000, 1, -1, ack, ren, lat, val, d, wr);
    check("kill accept", 64'(ack), 64'd1);
    check("kill no data_val", 64'(val), 64'd0);
    fetch(32'h2008, -1, -1, ack, ren, lat, val, d, wr);
    check("post-kill hit data_val", 64'(val), 64'd1);
    check("post-kill hit latency", 64'(lat), 64'd1);
    check("post-kill hit data", d, beat_data(32'h2008));

    // Invalidate during refill: delivery still happens, then one IDLE cycle
    // plus SETS INVAL cycles with read_ack low, then everything misses.
    fetch(32'h4000, -1, 2, ack, ren, lat, val, d, wr);
    check("inval refill data_val", 64'(val), 64'd1);
    check("inval refill data", d, beat_data(32'h4000));
    check("inval refill victim", 64'(wr), 64'd1);
    read_req = 1'b1;
    pc       = 32'h2000;
    zeros    = 0;
    #1;
    while (!read_ack && zeros < 200) begin
      zeros++;
      @(negedge clk);
      #1;
    end
    check("inval read_ack low cycles", 64'(zeros), 64'(SETS + 1));
    serve(-1, -1, lat, val, d, wr);
    check("post-inval miss latency", 64'(lat), 64'(MISS_LAT));
    check("post-inval data", d, beat_data(32'h2000));

    // Reset after two refill beats abandons the burst.
    issue(32'h3000, ack, ren);
    check("srst test accept", 64'(ack), 64'd1);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      read_req = 1'b0;
      reload_ack  = reload_req;
      reload_data = beat_data(reload_addr);
      @(posedge clk);
    end
    @(negedge clk);
    reload_ack = 1'b0;
    srst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    check("srst reload_req", 64'(reload_req), 64'd0);
    check("srst data_val", 64'(data_val), 64'd0);
    fetch(32'h3000, -1, -1, ack, ren, lat, val, d, wr);
    check("post-srst miss latency", 64'(lat), 64'(MISS_LAT));
    check("post-srst data", d, beat_data(32'h3000));
    fetch(32'h2008, -1, -1, ack, ren, lat, val, d, wr);
    check("post-srst old line misses", 64'(lat), 64'(MISS_LAT));

    // Fresh reset, then 2 misses and 3 hits.
    @(negedge clk);
    srst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    for (int i = 0; i < 5; i++) apply(perf_vecs[i], $sformatf("perf%0d", i));
`ifdef RISCV_ICACHE_PERF_EN
    check("hit_cnt", 64'(hit_cnt), 64'd3);
    check("miss_cnt", 64'(miss_cnt), 64'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
